// File: rtl/alarm_controller.sv
// Alarm time store plus ring/snooze controller driven by the 1 Hz time-of-day counter.
// Ring and snooze durations are counted in 1 Hz ticks by a single shared 9-bit timer.
module alarm_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       alarm_en,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       snooze,
    input  logic       stop,
    output logic       ring,
    output logic       snoozing,
    output logic [1:0] snooze_cnt,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam logic [8:0] RING_LAST    = 9'(RING_SECS - 1);
    localparam logic [8:0] SNOOZE_LAST  = 9'(SNOOZE_SECS - 1);
    localparam logic [1:0] SNOOZE_LIMIT = 2'(MAX_SNOOZE);
    localparam logic [8:0] TIMER_MAX    = 9'd511;

    state_t     state_reg, state_next;
    logic [8:0] timer_reg, timer_next;
    logic [1:0] snooze_cnt_reg, snooze_cnt_next;
    logic [4:0] alarm_hour_reg, alarm_hour_next;
    logic [5:0] alarm_min_reg, alarm_min_next;

    logic       set_valid;
    logic       match;
    logic [8:0] timer_inc;

    assign set_valid = set_en && (set_hour <= 5'd23) && (set_min <= 6'd59);
    assign match     = alarm_en && (hour == alarm_hour_reg) && (min == alarm_min_reg)
                       && (sec == 6'd0);
    assign timer_inc = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + 9'd1;

    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            timer_reg      <= 9'd0;
            snooze_cnt_reg <= 2'd0;
            alarm_hour_reg <= 5'd0;
            alarm_min_reg  <= 6'd0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            snooze_cnt_reg <= snooze_cnt_next;
            alarm_hour_reg <= alarm_hour_next;
            alarm_min_reg  <= alarm_min_next;
        end
    end

    // Alarm registers load independently of the FSM, even while disarmed.
    always_comb begin
        alarm_hour_next = alarm_hour_reg;
        alarm_min_next  = alarm_min_reg;
        if (set_valid) begin
            alarm_hour_next = set_hour;
            alarm_min_next  = set_min;
        end
    end

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_inc;
        snooze_cnt_next = snooze_cnt_reg;
        if (!alarm_en || set_valid) begin
            state_next      = IDLE;
            timer_next      = 9'd0;
            snooze_cnt_next = 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timer_next      = 9'd0;
                    snooze_cnt_next = 2'd0;
                    if (match) begin
                        state_next = RINGING;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_next      = IDLE;
                        timer_next      = 9'd0;
                        snooze_cnt_next = 2'd0;
                    end else if (snooze && (snooze_cnt_reg < SNOOZE_LIMIT)) begin
                        state_next      = SNOOZE;
                        timer_next      = 9'd0;
                        snooze_cnt_next = snooze_cnt_reg + 2'd1;
                    end else if (timer_reg == RING_LAST) begin
                        state_next      = IDLE;
                        timer_next      = 9'd0;
                        snooze_cnt_next = 2'd0;
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_next      = IDLE;
                        timer_next      = 9'd0;
                        snooze_cnt_next = 2'd0;
                    end else if (timer_reg == SNOOZE_LAST) begin
                        state_next = RINGING;
                        timer_next = 9'd0;
                    end
                end
                default: begin
                    state_next      = IDLE;
                    timer_next      = 9'd0;
                    snooze_cnt_next = 2'd0;
                end
            endcase
        end
    end

    // Outputs decode registers only, so no input reaches an output combinationally.
    always_comb begin
        ring       = (state_reg == RINGING);
        snoozing   = (state_reg == SNOOZE);
        snooze_cnt = snooze_cnt_reg;
        alarm_hour = alarm_hour_reg;
        alarm_min  = alarm_min_reg;
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Randomized bench for alarm_controller against a countdown-based model of alarm events.
module tb_alarm_controller;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int MAX_SNOOZE  = 3;

    logic       clk_1hz = 1'b0;
    logic       rst = 1'b1;
    logic       alarm_en = 1'b1;
    logic       set_en = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic [4:0] hour = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = 6'd1;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic       ring;
    logic       snoozing;
    logic [1:0] snooze_cnt;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;

    int  checks = 0;
    int  errors = 0;
    bit  time_run = 1'b0;

    // Model: an alarm event is a number of ring seconds left or silent seconds left.
    int m_ring_left, m_quiet_left, m_cnt, m_ah, m_am;

    alarm_controller #(
        .RING_SECS(RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk_1hz(clk_1hz),
        .rst(rst),
        .alarm_en(alarm_en),
        .set_en(set_en),
        .set_hour(set_hour),
        .set_min(set_min),
        .hour(hour),
        .min(min),
        .sec(sec),
        .snooze(snooze),
        .stop(stop),
        .ring(ring),
        .snoozing(snoozing),
        .snooze_cnt(snooze_cnt),
        .alarm_hour(alarm_hour),
        .alarm_min(alarm_min)
    );

    always #5 clk_1hz = ~clk_1hz;

    function automatic logic [14:0] model_vec();
        logic [1:0] c;
        logic [4:0] h;
        logic [5:0] m;
        c = 2'(m_cnt);
        h = 5'(m_ah);
        m = 6'(m_am);
        return {(m_ring_left > 0), (m_quiet_left > 0), c, h, m};
    endfunction

    task automatic model_reset();
        m_ring_left = 0; m_quiet_left = 0; m_cnt = 0; m_ah = 0; m_am = 0;
    endtask

    task automatic model_idle();
        m_ring_left = 0; m_quiet_left = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit valid_set, hit;
        valid_set = set_en && (int'(set_hour) <= 23) && (int'(set_min) <= 59);
        hit = alarm_en && (int'(hour) == m_ah) && (int'(min) == m_am) && (sec == 0);
        if (!alarm_en || valid_set) begin
            model_idle();
        end else if (m_ring_left > 0) begin
            if (stop) model_idle();
            else if (snooze && m_cnt < MAX_SNOOZE) begin
                m_cnt++;
                m_ring_left = 0;
                m_quiet_left = SNOOZE_SECS;
            end else begin
                m_ring_left--;
                if (m_ring_left == 0) model_idle();
            end
        end else if (m_quiet_left > 0) begin
            if (stop) model_idle();
            else begin
                m_quiet_left--;
                if (m_quiet_left == 0) m_ring_left = RING_SECS;
            end
        end else if (hit) begin
            m_ring_left = RING_SECS;
        end
        if (valid_set) begin
            m_ah = int'(set_hour);
            m_am = int'(set_min);
        end
    endtask

    task automatic tick();
        @(posedge clk_1hz);
        model_edge();
        @(negedge clk_1hz);
        if (time_run) begin
            if (sec == 6'd59) begin
                sec = 6'd0;
                if (min == 6'd59) begin
                    min = 6'd0;
                    hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                end else begin
                    min = min + 6'd1;
                end
            end else begin
                sec = sec + 6'd1;
            end
        end
    endtask

    task automatic load_time(input int h, input int m, input int s);
        hour = 5'(h); min = 6'(m); sec = 6'(s);
    endtask

    task automatic do_set(input int h, input int m);
        set_en = 1'b1; set_hour = 5'(h); set_min = 6'(m);
        tick();
        set_en = 1'b0;
        $display("set %0d:%0d -> alarm %0d:%0d", h, m, alarm_hour, alarm_min);
    endtask

    task automatic wait_ring(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ring === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #12;
        checks++;
        if ({ring, snoozing, snooze_cnt, alarm_hour, alarm_min} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {ring, snoozing, snooze_cnt, alarm_hour, alarm_min});
        end
        @(negedge clk_1hz);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_set_and_ring();
        bit ok;
        int n;
        do_set(7, 30);
        checks++;
        if (alarm_hour !== 5'd7 || alarm_min !== 6'd30) begin
            errors++;
            $display("FAIL set_0730 got %0d:%0d required 7:30", alarm_hour, alarm_min);
        end
        load_time(7, 29, 58);
        time_run = 1'b1;
        wait_ring(10, ok);
        checks++;
        if (!ok || hour !== 5'd7 || min !== 6'd30 || sec !== 6'd1) begin
            errors++;
            $display("FAIL ring_start ring=%0b at %0d:%0d:%0d required 1 at 7:30:1",
                     ring, hour, min, sec);
        end
        n = 1;
        for (int i = 0; i < RING_SECS + 10; i++) begin
            tick();
            if (ring === 1'b1) n++;
            else break;
        end
        checks++;
        if (n != RING_SECS) begin
            errors++;
            $display("FAIL ring_length got %0d required %0d", n, RING_SECS);
        end
        checks++;
        if ({ring, snoozing, snooze_cnt} !== 4'd0 || model_vec() !== {ring, snoozing, snooze_cnt, alarm_hour, alarm_min}) begin
            errors++;
            $display("FAIL ring_timeout_idle got %b%b%0d required 000", ring, snoozing, snooze_cnt);
        end
        $display("ring lasted %0d cycles", n);
    endtask

    task automatic test_bad_set();
        do_set(24, 10);
        checks++;
        if (alarm_hour !== 5'd7 || alarm_min !== 6'd30) begin
            errors++;
            $display("FAIL bad_hour got %0d:%0d required 7:30", alarm_hour, alarm_min);
        end
        do_set(12, 60);
        checks++;
        if (alarm_hour !== 5'd7 || alarm_min !== 6'd30) begin
            errors++;
            $display("FAIL bad_min got %0d:%0d required 7:30", alarm_hour, alarm_min);
        end
    endtask

    task automatic test_snooze();
        bit ok;
        int q;
        load_time(7, 29, 59);
        wait_ring(5, ok);
        for (int i = 0; i < 4; i++) tick();
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        checks++;
        if (!ok || ring !== 1'b0 || snoozing !== 1'b1 || snooze_cnt !== 2'd1) begin
            errors++;
            $display("FAIL snooze_entry ring=%0b snoozing=%0b cnt=%0d required 0 1 1",
                     ring, snoozing, snooze_cnt);
        end
        q = 1;
        for (int i = 0; i < SNOOZE_SECS + 10; i++) begin
            tick();
            if (snoozing === 1'b1) q++;
            else break;
        end
        checks++;
        if (q != SNOOZE_SECS || ring !== 1'b1 || snooze_cnt !== 2'd1) begin
            errors++;
            $display("FAIL snooze_length got %0d ring=%0b required %0d ring=1", q, ring, SNOOZE_SECS);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({ring, snoozing, snooze_cnt, alarm_hour, alarm_min} !== model_vec()) begin
            errors++;
            $display("FAIL snooze_stop got %h required %h",
                     {ring, snoozing, snooze_cnt, alarm_hour, alarm_min}, model_vec());
        end
        $display("snooze silent for %0d cycles", q);
    endtask

    task automatic test_max_snooze();
        bit ok;
        load_time(7, 29, 59);
        wait_ring(5, ok);
        for (int k = 1; k <= MAX_SNOOZE; k++) begin
            int d;
            d = $urandom_range(0, 20);
            for (int i = 0; i < d; i++) tick();
            snooze = 1'b1;
            tick();
            snooze = 1'b0;
            checks++;
            if (snooze_cnt !== 2'(k) || snoozing !== 1'b1 || model_vec() !== {ring, snoozing, snooze_cnt, alarm_hour, alarm_min}) begin
                errors++;
                $display("FAIL snooze_count got %0d snoozing=%0b required %0d 1", snooze_cnt, snoozing, k);
            end
            wait_ring(SNOOZE_SECS + 5, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL snooze_rering ring=%0b required 1", ring);
            end
        end
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        checks++;
        if (ring !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 2'd3) begin
            errors++;
            $display("FAIL snooze_limit ring=%0b snoozing=%0b cnt=%0d required 1 0 3",
                     ring, snoozing, snooze_cnt);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (ring !== 1'b0 || snooze_cnt !== 2'd0) begin
            errors++;
            $display("FAIL limit_stop ring=%0b cnt=%0d required 0 0", ring, snooze_cnt);
        end
        $display("snooze limit exercised");
    endtask

    task automatic test_stop_and_snooze();
        bit ok;
        load_time(7, 29, 59);
        wait_ring(5, ok);
        tick();
        stop = 1'b1; snooze = 1'b1;
        tick();
        stop = 1'b0; snooze = 1'b0;
        checks++;
        if (!ok || {ring, snoozing, snooze_cnt} !== 4'd0) begin
            errors++;
            $display("FAIL stop_snooze got %b%b%0d required 000", ring, snoozing, snooze_cnt);
        end
    endtask

    task automatic test_midnight();
        bit ok;
        do_set(0, 0);
        load_time(23, 59, 58);
        wait_ring(10, ok);
        checks++;
        if (!ok || hour !== 5'd0 || min !== 6'd0 || sec !== 6'd1) begin
            errors++;
            $display("FAIL midnight ring=%0b at %0d:%0d:%0d required 1 at 0:0:1", ring, hour, min, sec);
        end
        for (int i = 0; i < 3; i++) tick();
        alarm_en = 1'b0;
        tick();
        checks++;
        if (ring !== 1'b0 || ring !== (m_ring_left > 0)) begin
            errors++;
            $display("FAIL disarm_midring ring=%0b required 0", ring);
        end
        load_time(23, 59, 59);
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ring !== 1'b0) ok = 1'b1;
        end
        checks++;
        if (ok) begin
            errors++;
            $display("FAIL disarmed_match ring=1 required 0");
        end
        alarm_en = 1'b1;
        $display("midnight and disarm done");
    endtask

    task automatic test_async_reset();
        bit ok;
        int h, m;
        h = $urandom_range(0, 23);
        m = $urandom_range(0, 59);
        time_run = 1'b0;
        do_set(h, m);
        load_time(h, m, 0);
        wait_ring(3, ok);
        load_time(h, m, 5);
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        tick();
        checks++;
        if (!ok || snoozing !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_snooze snoozing=%0b required 1", snoozing);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ring, snoozing, snooze_cnt, alarm_hour, alarm_min} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset got %h required 0",
                     {ring, snoozing, snooze_cnt, alarm_hour, alarm_min});
        end
        model_reset();
        @(negedge clk_1hz);
        rst = 1'b0;
        $display("async reset during snooze at alarm %0d:%0d", h, m);
    endtask

    task automatic test_random();
        int bad = 0;
        do_set($urandom_range(0, 23), $urandom_range(0, 59));
        time_run = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            alarm_en = ($urandom_range(0, 199) != 0);
            set_en   = ($urandom_range(0, 149) == 0);
            set_hour = 5'($urandom_range(0, 31));
            set_min  = 6'($urandom_range(0, 63));
            snooze   = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) == 0) load_time(m_ah, m_am, 0);
            tick();
            checks++;
            if ({ring, snoozing, snooze_cnt, alarm_hour, alarm_min} !== model_vec()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle %0d got %h required %h", i,
                             {ring, snoozing, snooze_cnt, alarm_hour, alarm_min}, model_vec());
            end
        end
        set_en = 1'b0; snooze = 1'b0; stop = 1'b0; alarm_en = 1'b1;
        $display("random phase: 4000 cycles, %0d differing", bad);
    endtask

    initial begin
        test_reset();
        test_set_and_ring();
        test_bad_set();
        test_snooze();
        test_max_snooze();
        test_stop_and_snooze();
        test_midnight();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
